// File: rtl/fpu_types.sv
// Shared FPU writeback types: fflags layout and the producer result record.
package fpu_types;
  localparam int FFLAGS_W = 5;
  localparam int FP_ID_W  = 3;
  localparam int FP_FLEN  = 64;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic [FP_ID_W-1:0] id;
    logic [FP_FLEN-1:0] data;
    fflags_t            fflags;
  } fp_wb_src_t;
endpackage

// File: rtl/fp_wb_rr_arbiter.sv
// One-hot grant arbiter for FP writeback producers.
// FP_WB_COMMIT_RR_EN selects round-robin; otherwise lowest index wins.
module fp_wb_rr_arbiter #(
  parameter int NUM_SRC = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_SRC-1:0] o_gnt
);
`ifdef FP_WB_COMMIT_RR_EN
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] w_win;
  int               w_best;
  int               w_dist;

  // Distance from last_grant+1 (mod NUM_SRC); smallest requesting distance wins.
  always_comb begin
    o_gnt  = '0;
    w_win  = r_last;
    w_best = NUM_SRC;
    w_dist = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_dist = (i + NUM_SRC - 1 - int'(r_last)) % NUM_SRC;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        w_win    = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)           r_last <= IDX_W'(NUM_SRC - 1);
    else if (i_advance) r_last <= w_win;
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, i_advance};

  always_comb begin
    o_gnt = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
      end
    end
  end
`endif
endmodule

// File: rtl/fp_wb_commit.sv
// FP writeback commit: arbitrates producers into a one-entry output stage and
// accumulates sticky fflags. FP_WB_COMMIT_RR_EN enables round-robin arbitration.
module fp_wb_commit
  import fpu_types::*;
#(
  parameter int NUM_SRC = 2,
  parameter int ID_W    = 3,
  parameter int FLEN    = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                src_done,
  output logic [NUM_SRC-1:0]                src_ack,
  input  logic [NUM_SRC-1:0][ID_W-1:0]      src_id,
  input  logic [NUM_SRC-1:0][FLEN-1:0]      src_data,
  input  logic [NUM_SRC-1:0][FFLAGS_W-1:0]  src_fflags,
  output logic                              wb_valid,
  input  logic                              wb_ready,
  output logic [ID_W-1:0]                   wb_id,
  output logic [FLEN-1:0]                   wb_data,
  input  logic                              csr_we,
  input  logic [FFLAGS_W-1:0]               csr_wdata,
  output logic [FFLAGS_W-1:0]               fflags
);
  logic               r_valid;
  logic [ID_W-1:0]    r_id;
  logic [FLEN-1:0]    r_data;
  fflags_t            r_fflags;

  logic               w_can_accept;
  logic [NUM_SRC-1:0] w_req;
  logic [NUM_SRC-1:0] w_gnt;
  logic               w_accept;
  logic [ID_W-1:0]    w_win_id;
  logic [FLEN-1:0]    w_win_data;
  fflags_t            w_acc;

  // Gating requests with rst keeps acks low during reset without touching the arbiter.
  assign w_can_accept = ~r_valid | wb_ready;
  assign w_req        = src_done & {NUM_SRC{w_can_accept & rst}};
  assign w_accept     = |w_gnt;
  assign src_ack      = w_gnt;

  fp_wb_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_advance (w_accept),
    .o_gnt     (w_gnt)
  );

  always_comb begin
    w_win_id   = '0;
    w_win_data = '0;
    w_acc      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_gnt[i]) begin
        w_win_id   = src_id[i];
        w_win_data = src_data[i];
        w_acc      = src_fflags[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_data   <= '0;
      r_fflags <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_id    <= w_win_id;
        r_data  <= w_win_data;
      end else if (wb_ready) begin
        r_valid <= 1'b0;
      end
      r_fflags <= (csr_we ? fflags_t'(csr_wdata) : r_fflags) | w_acc;
    end
  end

  assign wb_valid = r_valid;
  assign wb_id    = r_id;
  assign wb_data  = r_data;
  assign fflags   = r_fflags;
endmodule
